// File: rtl/spike_dispatch_scheduler.sv
// Spike dispatch scheduler for one accelerator tile.
// Buffers {origin, destination} spike packets in a small FIFO, delivers them
// one at a time to the local MAC units at a paced rate, discards packets that
// are not addressed to this tile, and produces the timestep clear pulse. A
// timestep is held open (DRAIN) until every buffered spike has been delivered.
module spike_dispatch_scheduler #(
    parameter int NUM_NEURONS       = 10,
    parameter int ADDR_W            = 12,
    parameter int FIFO_DEPTH        = 8,
    parameter int TIMESTEP_CYCLES   = 4,
    parameter int DISPATCH_INTERVAL = 2
) (
    input  logic                          CLK,
    input  logic                          RESET_N,
    input  logic [ADDR_W-1:0]             base_address,
    input  logic [2*ADDR_W-1:0]           packet_in,
    input  logic                          packet_valid,
    output logic                          packet_ready,
    output logic [ADDR_W-1:0]             source_address_out,
    output logic [NUM_NEURONS-1:0]        mac_valid,
    output logic                          clear,
    output logic [15:0]                   timestep_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [7:0]                    drop_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CW    = PTR_W + 1;
    localparam int CNT_W = $clog2(TIMESTEP_CYCLES + 1);
    localparam int GAP_W = $clog2(DISPATCH_INTERVAL + 1);

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_CLEAR  = 2'd2
    } state_t;

    state_t                  state_reg;
    state_t                  state_next;

    logic [2*ADDR_W-1:0]     fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_reg;
    logic [PTR_W-1:0]        rd_ptr_reg;
    logic [CW-1:0]           count_reg;
    logic [CW-1:0]           count_next;

    logic [CNT_W-1:0]        cycle_cnt_reg;
    logic [GAP_W-1:0]        gap_cnt_reg;

    logic                    dispatch_ok;
    logic                    push;
    logic                    pop;

    logic [2*ADDR_W-1:0]     head;
    logic [ADDR_W-1:0]       head_origin;
    logic [ADDR_W-1:0]       head_idx;
    logic [NUM_NEURONS-1:0]  head_onehot;
    logic                    head_local;

    // Head-of-FIFO decode: destination relative to this tile's neuron 0.
    // The subtraction wraps modulo 2^ADDR_W, so destinations below the base
    // land far above NUM_NEURONS and are treated as non-local.
    assign head        = fifo_mem[rd_ptr_reg];
    assign head_origin = head[2*ADDR_W-1:ADDR_W];
    assign head_idx    = head[ADDR_W-1:0] - base_address;

    generate
        for (genvar gi = 0; gi < NUM_NEURONS; gi++) begin : g_decode
            assign head_onehot[gi] = (head_idx == ADDR_W'(gi));
        end
    endgenerate

    assign head_local = |head_onehot;

    // A packet pushed into an empty FIFO is not visible to pop until the next
    // cycle because pop looks at the registered occupancy.
    assign push       = packet_valid && packet_ready;
    assign pop        = dispatch_ok && (count_reg != '0) && (gap_cnt_reg == '0);
    assign count_next = count_reg + CW'(push) - CW'(pop);
    assign fifo_count = count_reg;

    // FSM state register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg <= ST_ACCEPT;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next state: leave ACCEPT at the end of the nominal window, and only
    // enter CLEAR once the buffer will be empty.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_ACCEPT: begin
                if (cycle_cnt_reg == CNT_W'(TIMESTEP_CYCLES - 2)) begin
                    state_next = (count_next == '0) ? ST_CLEAR : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (count_next == '0) begin
                    state_next = ST_CLEAR;
                end
            end
            ST_CLEAR: state_next = ST_ACCEPT;
            default:  state_next = ST_ACCEPT;
        endcase
    end

    // FSM outputs decoded from the registered state only.
    always_comb begin
        packet_ready = 1'b0;
        clear        = 1'b0;
        dispatch_ok  = 1'b0;
        case (state_reg)
            ST_ACCEPT: begin
                packet_ready = (count_reg < CW'(FIFO_DEPTH));
                dispatch_ok  = 1'b1;
            end
            ST_DRAIN: dispatch_ok = 1'b1;
            ST_CLEAR: clear       = 1'b1;
            default: begin
                packet_ready = 1'b0;
            end
        endcase
    end

    // Packet storage; contents need no reset because occupancy gates reads.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= packet_in;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_next;
        end
    end

    // Timestep bookkeeping: cycle counter runs in ACCEPT, holds in DRAIN,
    // and restarts at CLEAR, which also closes the timestep.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cycle_cnt_reg  <= '0;
            timestep_count <= '0;
        end else begin
            case (state_reg)
                ST_ACCEPT: cycle_cnt_reg <= cycle_cnt_reg + CNT_W'(1);
                ST_CLEAR: begin
                    cycle_cnt_reg  <= '0;
                    timestep_count <= timestep_count + 16'd1;
                end
                default: cycle_cnt_reg <= cycle_cnt_reg;
            endcase
        end
    end

    // Dispatch pacing: after a pop, hold off the next one so the MAC has time
    // to finish accumulating.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            gap_cnt_reg <= '0;
        end else if (pop) begin
            gap_cnt_reg <= GAP_W'(DISPATCH_INTERVAL - 1);
        end else if (gap_cnt_reg != '0) begin
            gap_cnt_reg <= gap_cnt_reg - GAP_W'(1);
        end
    end

    // Dispatch result one cycle after the pop: strobe the target MAC or count
    // a drop. The source address keeps its last value across drops.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            mac_valid          <= '0;
            source_address_out <= '0;
            drop_count         <= '0;
        end else begin
            mac_valid <= '0;
            if (pop) begin
                if (head_local) begin
                    mac_valid          <= head_onehot;
                    source_address_out <= head_origin;
                end else if (drop_count != 8'hFF) begin
                    drop_count <= drop_count + 8'd1;
                end
            end
        end
    end

endmodule
